// File: rtl/dsp_pipe_pkg.sv
// Shared constants and helpers for the DSP operand delay line.
// Stages carry a valid bit alongside the operand.
package dsp_pipe_pkg;

    localparam int unsigned MAX_DEPTH_LIMIT = 8;

    // Requested latency saturates at the physical chain depth.
    function automatic int unsigned clamp_lat(
        input int unsigned sel,
        input int unsigned depth
    );
        int unsigned lim;
        lim = (depth > MAX_DEPTH_LIMIT) ? MAX_DEPTH_LIMIT : depth;
        return (sel > lim) ? lim : sel;
    endfunction

endpackage

// File: rtl/dsp_pipe_cell.sv
// One stage of the operand delay line: {valid, data} register
// with async reset, sync clear and clock enable.
module dsp_pipe_cell
    import dsp_pipe_pkg::*;
#(
    parameter type stage_t = logic [18:0]
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   sclr,
    input  logic   cen,
    input  stage_t d,
    output stage_t q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (sclr) begin
            q <= '0;
        end else if (cen) begin
            q <= d;
        end
    end

endmodule

// File: rtl/dsp_pipe_line.sv
// Selectable-latency operand delay line with stall, clear and
// a refill guard that hides stale words after a latency change.
module dsp_pipe_line
    import dsp_pipe_pkg::*;
#(
    parameter int WIDTH       = 18,
    parameter int MAX_DEPTH   = 4,
    parameter int DEFAULT_LAT = 1,
    localparam int LW         = $clog2(MAX_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cen,
    input  logic             sclr,
    input  logic [LW-1:0]    lat_sel,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             lat_busy
);

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] data;
    } stage_t;

    stage_t        stg_d [MAX_DEPTH];
    stage_t        stg_q [MAX_DEPTH];
    stage_t        head;
    stage_t        tap;
    logic [LW-1:0] lat_cl;
    logic [LW-1:0] lat_q;
    logic [LW-1:0] fill_cnt;

    assign head = '{valid: in_valid, data: in_data};

    assign lat_cl = LW'(clamp_lat(
        int'(lat_sel), int'(MAX_DEPTH)));

    for (genvar k = 0; k < MAX_DEPTH; k++) begin : g_cell
        if (k == 0) begin : g_head
            assign stg_d[k] = head;
        end else begin : g_link
            assign stg_d[k] = stg_q[k-1];
        end

        dsp_pipe_cell #(
            .stage_t (stage_t)
        ) u_cell (
            .clk   (clk),
            .rst_n (rst_n),
            .sclr  (sclr),
            .cen   (cen),
            .d     (stg_d[k]),
            .q     (stg_q[k])
        );
    end

    // Chain contents survive a latency change, so the guard
    // counts the new depth's worth of shifts before trusting it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_q    <= LW'(DEFAULT_LAT);
            fill_cnt <= '0;
        end else begin
            lat_q <= lat_cl;
            if (sclr) begin
                fill_cnt <= '0;
            end else if (lat_cl != lat_q) begin
                fill_cnt <= lat_cl;
            end else if (cen && fill_cnt != '0) begin
                fill_cnt <= fill_cnt - LW'(1);
            end
        end
    end

    always_comb begin
        tap = head;
        for (int k = 0; k < MAX_DEPTH; k++) begin
            if (lat_q == LW'(k + 1)) begin
                tap = stg_q[k];
            end
        end
    end

    assign lat_busy  = (fill_cnt != '0);
    assign out_data  = tap.data;
    assign out_valid = tap.valid & ~lat_busy;

endmodule

// File: tb/tb_dsp_pipe_line.sv
// Directed bench for dsp_pipe_line: reset, fixed latency, stall,
// latency changes, sync clear and latency clamp.
module tb_dsp_pipe_line;

    localparam int WIDTH = 18;
    localparam int LW    = 3;

    logic             clk;
    logic             rst_n;
    logic             cen;
    logic             sclr;
    logic [LW-1:0]    lat_sel;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             lat_busy;

    int n_checks;
    int n_fails;
    int ne;

    dsp_pipe_line #(
        .WIDTH       (WIDTH),
        .MAX_DEPTH   (4),
        .DEFAULT_LAT (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cen       (cen),
        .sclr      (sclr),
        .lat_sel   (lat_sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .out_data  (out_data),
        .out_valid (out_valid),
        .lat_busy  (lat_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h",
                     tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive(input logic [WIDTH-1:0] d,
                         input logic v);
        in_data  = d;
        in_valid = v;
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst_n    = 1'b0;
        cen      = 1'b1;
        sclr     = 1'b0;
        lat_sel  = 3'd1;
        drive('0, 1'b0);

        // reset and async reset mid-stream
        tick();
        check("rst_data", 32'(out_data), 32'h0);
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_busy", 32'(lat_busy), 32'h0);
        rst_n = 1'b1;
        drive(18'h00ABC, 1'b1);
        tick();
        check("pre_rst_data", 32'(out_data), 32'h00ABC);
        check("pre_rst_valid", 32'(out_valid), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_data", 32'(out_data), 32'h0);
        check("async_rst_valid", 32'(out_valid), 32'h0);
        check("async_rst_busy", 32'(lat_busy), 32'h0);
        tick();
        rst_n = 1'b1;
        drive(18'h155AA, 1'b1);
        tick();
        check("post_rst_data", 32'(out_data), 32'h155AA);
        check("post_rst_valid", 32'(out_valid), 32'h1);

        // fixed latency 3
        lat_sel = 3'd3;
        drive('0, 1'b0);
        tick();
        check("lat3_busy", 32'(lat_busy), 32'h1);
        repeat (3) tick();
        check("lat3_settled", 32'(lat_busy), 32'h0);
        for (int j = 0; j < 8; j++) begin
            if (j >= 3) begin
                check("lat3_data", 32'(out_data), 32'(j - 2));
                check("lat3_valid", 32'(out_valid), 32'h1);
            end else begin
                check("lat3_idle", 32'(out_valid), 32'h0);
            end
            if (j < 5) drive(WIDTH'(j + 1), 1'b1);
            else       drive('0, 1'b0);
            tick();
        end

        // stall at latency 2
        lat_sel = 3'd2;
        drive('0, 1'b0);
        repeat (3) tick();
        check("lat2_settled", 32'(lat_busy), 32'h0);
        ne = 0;
        for (int j = 0; j < 14; j++) begin
            if (ne >= 2 && ne - 2 < 8) begin
                check("stall_data", 32'(out_data), 32'(16 + ne - 2));
                check("stall_valid", 32'(out_valid), 32'h1);
            end else begin
                check("stall_idle", 32'(out_valid), 32'h0);
            end
            cen = !(j >= 5 && j < 9);
            if (!cen)       drive(18'h3FFFF, 1'b1);
            else if (ne < 8) drive(WIDTH'(16 + ne), 1'b1);
            else            drive('0, 1'b0);
            tick();
            if (cen) ne++;
        end

        // latency 1 -> 4 while streaming
        cen     = 1'b1;
        lat_sel = 3'd1;
        drive('0, 1'b0);
        repeat (2) tick();
        check("lat1_settled", 32'(lat_busy), 32'h0);
        for (int j = 0; j < 12; j++) begin
            if (j >= 1 && j <= 3) begin
                check("l1_data", 32'(out_data), 32'(32 + j - 1));
                check("l1_valid", 32'(out_valid), 32'h1);
            end else if (j >= 4 && j <= 7) begin
                check("l4_busy", 32'(lat_busy), 32'h1);
                check("l4_masked", 32'(out_valid), 32'h0);
            end else if (j >= 8) begin
                check("l4_busy_clr", 32'(lat_busy), 32'h0);
                check("l4_data", 32'(out_data), 32'(32 + j - 4));
                check("l4_valid", 32'(out_valid), 32'h1);
            end
            if (j == 3) lat_sel = 3'd4;
            drive(WIDTH'(32 + j), 1'b1);
            tick();
        end

        // latency 4 -> 0
        lat_sel = 3'd0;
        drive(18'h2AAAA, 1'b1);
        tick();
        drive(18'h15555, 1'b1);
        #1;
        check("l0_busy", 32'(lat_busy), 32'h0);
        check("l0_data", 32'(out_data), 32'h15555);
        check("l0_valid", 32'(out_valid), 32'h1);
        drive(18'h00777, 1'b0);
        #1;
        check("l0_inv_data", 32'(out_data), 32'h00777);
        check("l0_inv_valid", 32'(out_valid), 32'h0);
        tick();
        check("l0_busy2", 32'(lat_busy), 32'h0);

        // sclr with cen=0 and latency change together
        drive(18'h12345, 1'b1);
        tick();
        cen     = 1'b0;
        sclr    = 1'b1;
        lat_sel = 3'd2;
        tick();
        check("clr_busy", 32'(lat_busy), 32'h0);
        check("clr_data", 32'(out_data), 32'h0);
        check("clr_valid", 32'(out_valid), 32'h0);
        sclr = 1'b0;
        cen  = 1'b1;
        drive(18'h0ABCD, 1'b1);
        tick();
        check("clr_fill_valid", 32'(out_valid), 32'h0);
        check("clr_fill_data", 32'(out_data), 32'h0);
        drive('0, 1'b0);
        tick();
        check("clr_word_data", 32'(out_data), 32'h0ABCD);
        check("clr_word_valid", 32'(out_valid), 32'h1);
        check("clr_word_busy", 32'(lat_busy), 32'h0);

        // clamp: 7 behaves as 4
        lat_sel = 3'd7;
        tick();
        check("clamp_busy", 32'(lat_busy), 32'h1);
        repeat (4) tick();
        check("clamp_settled", 32'(lat_busy), 32'h0);
        for (int j = 0; j < 6; j++) begin
            if (j == 4) begin
                check("clamp_data", 32'(out_data), 32'h3FFFF);
                check("clamp_valid", 32'(out_valid), 32'h1);
            end else if (j > 0) begin
                check("clamp_idle", 32'(out_valid), 32'h0);
            end
            if (j == 0) drive(18'h3FFFF, 1'b1);
            else        drive('0, 1'b0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule
